// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM encoding,
// default latencies and the divide-by-zero result constant.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  localparam int          MUL_LAT_DEF = 4;
  localparam int          DIV_LAT_DEF = 33;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// busy drops in the cycle of the final iteration so the caller can move on at that edge.
module md_divider #(
  parameter int ITERS = 32
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam int CW = $clog2(ITERS);

  logic          run;
  logic [CW-1:0] cnt;
  logic [31:0]   quo, rem, dvs;
  logic [32:0]   sh, diff;
  logic          ge;

  assign sh   = {rem, quo[31]};
  assign diff = sh - {1'b0, dvs};
  assign ge   = (sh >= {1'b0, dvs});

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(ITERS - 1);
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  // iteration datapath: shift in next dividend bit, subtract if it fits
  always_ff @(posedge Clk) begin
    if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (run) begin
      rem <= ge ? diff[31:0] : sh[31:0];
      quo <= {quo[30:0], ge};
    end
  end

  assign busy = run && (cnt != '0);
  assign q    = quo;
  assign r    = rem;

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply-divide unit: fixed-latency mult, iterative div with sign fixup,
// mthi/mtlo writes and a stall handshake toward the upstream pipeline.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        md_start,
  input  logic [2:0]  md_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        md_busy,
  output logic        md_stall,
  output logic        md_done
);

  localparam int DIV_ITERS = DIV_LAT - 1;

  md_state_e          state, state_nx;
  md_op_e             op;
  logic [7:0]         cnt;
  logic [31:0]        a_q, b_q;
  logic               sgn_q;
  logic signed [63:0] a_ext, b_ext, prod;
  logic               div_start, div_busy;
  logic [31:0]        div_q, div_r, q_fix, r_fix, mag_a, mag_b;
  logic [31:0]        hi_nx, lo_nx;
  logic               done_c;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  assign op    = md_op_e'(md_control);
  assign mag_a = abs32(A, ~md_control[0]);
  assign mag_b = abs32(B, ~md_control[0]);

  md_divider #(.ITERS(DIV_ITERS)) u_div (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .busy     (div_busy),
    .q        (div_q),
    .r        (div_r)
  );

  // unsigned ops zero-extend, so one 64-bit multiply serves both signednesses
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? -div_q : div_q;
  assign r_fix = (sgn_q && a_q[31]) ? -div_r : div_r;

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    done_c    = 1'b0;
    hi_nx     = res_hi;
    lo_nx     = res_lo;
    unique case (state)
      ST_IDLE: begin
        if (md_start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: state_nx = ST_MUL;
            OP_DIV, OP_DIVU: begin
              state_nx  = ST_DIV;
              div_start = 1'b1;
            end
            OP_MTHI: hi_nx = A;
            OP_MTLO: lo_nx = A;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) state_nx = ST_IDLE;
        else if (cnt == '0) begin
          state_nx = ST_IDLE;
          done_c   = 1'b1;
          hi_nx    = prod[63:32];
          lo_nx    = prod[31:0];
        end
      end
      ST_DIV: begin
        if (flush)          state_nx = ST_IDLE;
        else if (!div_busy) state_nx = ST_FIX;
      end
      ST_FIX: begin
        state_nx = ST_IDLE;
        if (!flush) begin
          done_c = 1'b1;
          if (b_q == '0) begin
            hi_nx = a_q;
            lo_nx = DIV_ZERO_LO;
          end else begin
            hi_nx = r_fix;
            lo_nx = q_fix;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state   <= ST_IDLE;
      res_hi  <= '0;
      res_lo  <= '0;
      md_busy <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      res_hi  <= hi_nx;
      res_lo  <= lo_nx;
      md_busy <= (state_nx != ST_IDLE);
      if (state == ST_IDLE && state_nx == ST_MUL) cnt <= 8'(MUL_LAT - 1);
      else if (state == ST_MUL && cnt != '0)      cnt <= cnt - 1'b1;
    end
  end

  // operands and signedness frozen at the accept edge
  always_ff @(posedge Clk) begin
    if (state == ST_IDLE && state_nx != ST_IDLE) begin
      a_q   <= A;
      b_q   <= B;
      sgn_q <= ~md_control[0];
    end
  end

  assign md_done  = done_c;
  assign md_stall = md_start & md_busy;

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized bench for md_sequencer against an arithmetic HI/LO reference model.
module tb_md_sequencer;

  localparam logic [2:0] C_MULT = 3'b000, C_MULTU = 3'b001, C_DIV = 3'b010, C_DIVU = 3'b011;
  localparam logic [2:0] C_MTHI = 3'b100, C_MTLO = 3'b101, C_MFHI = 3'b110, C_MFLO = 3'b111;
  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 33;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic        md_start;
  logic [2:0]  md_control;
  logic [31:0] A, B;
  logic        flush;
  logic [31:0] res_hi, res_lo;
  logic        md_busy, md_stall, md_done;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  md_sequencer dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .md_start   (md_start),
    .md_control (md_control),
    .A          (A),
    .B          (B),
    .flush      (flush),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .md_busy    (md_busy),
    .md_stall   (md_stall),
    .md_done    (md_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // architectural effect of one completed instruction
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint p, sa, sb;
    case (op)
      C_MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      C_MULTU: begin
        p  = longint'({32'b0, a}) * longint'({32'b0, b});
        hi = p[63:32];
        lo = p[31:0];
      end
      C_DIV, C_DIVU: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == C_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else if (op == C_DIV) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          hi = 32'(sa % sb);
          lo = 32'(sa / sb);
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      C_MTHI: hi = a;
      C_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // called right after a negedge while the unit is idle
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold_mf);
    int lat;
    logic [31:0] ohi, olo;
    ohi = hi_m;
    olo = lo_m;
    md_start = 1'b1; md_control = op; A = a; B = b; flush = 1'b0;
    #1;
    check("stall_idle", md_stall, 0);
    @(posedge Clk);
    @(negedge Clk);
    model(op, a, b, hi_m, lo_m);
    if (op[2]) begin
      md_start = 1'b0;
      #1;
      check("mt_mf_hi", res_hi, hi_m);
      check("mt_mf_lo", res_lo, lo_m);
      check("mt_mf_busy", md_busy, 0);
      check("mt_mf_done", md_done, 0);
      return;
    end
    lat = op[1] ? DIV_CYC : MUL_CYC;
    if (hold_mf) begin md_start = 1'b1; md_control = C_MFHI; end
    else md_start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      A = $urandom; B = $urandom;
      #1;
      check("busy_during", md_busy, 1);
      check("done_timing", md_done, (k == lat));
      check("stall_during", md_stall, hold_mf);
      check("hi_hold", res_hi, ohi);
      check("lo_hold", res_lo, olo);
      @(negedge Clk);
    end
    #1;
    check("busy_after", md_busy, 0);
    check("done_after", md_done, 0);
    check("stall_after", md_stall, 0);
    check("hi_result", res_hi, hi_m);
    check("lo_result", res_lo, lo_m);
    if (hold_mf) begin
      @(negedge Clk);
      md_start = 1'b0;
      #1;
      check("mfhi_retry_hi", res_hi, hi_m);
      check("mfhi_retry_busy", md_busy, 0);
    end
  endtask

  // start op, flush in busy cycle 'at', expect no write and no done
  task automatic do_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int at);
    int pulses;
    logic [31:0] ohi, olo;
    ohi = hi_m;
    olo = lo_m;
    pulses = 0;
    md_start = 1'b1; md_control = op; A = a; B = b; flush = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    md_start = 1'b0;
    for (int k = 1; k <= at; k++) begin
      if (k == at) flush = 1'b1;
      #1;
      check("flush_busy", md_busy, 1);
      check("flush_done", md_done, 0);
      @(negedge Clk);
    end
    flush = 1'b0;
    #1;
    check("flush_idle", md_busy, 0);
    check("flush_hi", res_hi, ohi);
    check("flush_lo", res_lo, olo);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (md_done) pulses++;
    end
    check("flush_no_late_done", pulses, 0);
    check("flush_hi_late", res_hi, ohi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int op, at;
    logic [31:0] a, b, ohi;
    Clrn = 1'b1; md_start = 1'b0; md_control = 3'b0; A = '0; B = '0; flush = 1'b0;
    #2 Clrn = 1'b0;
    #1;
    check("rst_hi", res_hi, 0);
    check("rst_lo", res_lo, 0);
    check("rst_busy", md_busy, 0);
    check("rst_done", md_done, 0);
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;

    do_op(C_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi_const", res_hi, 32'hFFFF_FFFF);
    check("mult_lo_const", res_lo, 32'hFFFF_FFFA);
    do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo_const", res_lo, 32'hFFFF_FFFD);
    check("div_hi_const", res_hi, 32'hFFFF_FFFF);
    do_op(C_DIVU, 32'd100, 32'd7, 0);
    check("divu_lo_const", res_lo, 32'd14);
    check("divu_hi_const", res_hi, 32'd2);
    do_op(C_DIVU, 32'd5, 32'd0, 0);
    check("div0_hi_const", res_hi, 32'd5);
    check("div0_lo_const", res_lo, 32'hFFFF_FFFF);
    do_op(C_DIV, 32'hFFFF_FFFB, 32'd0, 0);
    do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo_const", res_lo, 32'h8000_0000);
    check("ovf_hi_const", res_hi, 32'd0);
    do_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(C_MFLO, 32'h1111, 32'h2222, 0);

    do_op(C_MTHI, 32'h5555_AAAA, 32'd0, 0);
    do_op(C_DIVU, 32'd1000, 32'd3, 1);

    do_op(C_MTHI, 32'h1234, 32'd0, 0);
    do_flush(C_DIV, 32'd50, 32'd7, 10);
    check("flush_hi_const", res_hi, 32'h1234);
    do_flush(C_MULT, 32'd3, 32'd5, MUL_CYC);

    ohi = hi_m;
    md_start = 1'b1; md_control = C_MTHI; A = 32'hDEAD; flush = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    md_start = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_noaccept_hi", res_hi, ohi);
    check("flush_idle_noaccept_busy", md_busy, 0);

    md_start = 1'b1; md_control = C_MULT; A = 32'd7; B = 32'd9;
    @(posedge Clk);
    @(negedge Clk);
    md_start = 1'b0;
    @(negedge Clk);
    #2 Clrn = 1'b0;
    #1;
    check("arst_hi", res_hi, 0);
    check("arst_lo", res_lo, 0);
    check("arst_busy", md_busy, 0);
    check("arst_done", md_done, 0);
    hi_m = '0;
    lo_m = '0;
    @(negedge Clk);
    #2 Clrn = 1'b1;
    md_start = 1'b1; md_control = C_MTHI; A = 32'hAA;
    @(posedge Clk);
    @(negedge Clk);
    md_start = 1'b0;
    model(C_MTHI, 32'hAA, 32'd0, hi_m, lo_m);
    #1;
    check("arst_mthi_hi", res_hi, 32'hAA);
    check("arst_mthi_lo", res_lo, 32'd0);
    begin
      int pulses = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge Clk);
        if (md_done) pulses++;
      end
      check("arst_no_done", pulses, 0);
    end

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if (op <= 3 && $urandom_range(0, 4) == 0) begin
        at = int'($urandom_range(1, (op >= 2) ? DIV_CYC : MUL_CYC));
        do_flush(3'(op), a, b, at);
      end else begin
        do_op(3'(op), a, b, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
